nanorv32_trace_capture: RTL



---
 rtl/nanorv32_trace_pkg.sv | 35 +++
 rtl/nanorv32_trace_fifo.sv | 57 +++++
 rtl/nanorv32_trace_capture.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/nanorv32_trace_pkg.sv
// Shared types for the nanorv32 retirement-trace collector: record layout,
// record kinds and capture FSM states.
package nanorv32_trace_pkg;

   localparam int TRACE_KIND_W  = 2;
   localparam int TRACE_PC_W    = 32;
   localparam int TRACE_INSTR_W = 32;
   localparam int TRACE_ADDR_W  = 32;
   localparam int TRACE_DATA_W  = 32;
   localparam int TRACE_REG_W   = 5;
   localparam int TRACE_REC_W   = TRACE_KIND_W + TRACE_PC_W + TRACE_INSTR_W +
                                  TRACE_ADDR_W + TRACE_DATA_W + TRACE_REG_W;

   typedef enum logic [TRACE_KIND_W-1:0] {
      TRACE_ALU   = 2'd0,
      TRACE_LOAD  = 2'd1,
      TRACE_STORE = 2'd2
   } trace_kind_e;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      LOAD_WAIT  = 2'd1,
      STORE_WAIT = 2'd2
   } trace_state_e;

   typedef struct packed {
      trace_kind_e               kind;
      logic [TRACE_PC_W-1:0]     pc;
      logic [TRACE_INSTR_W-1:0]  instr;
      logic [TRACE_ADDR_W-1:0]   addr;
      logic [TRACE_DATA_W-1:0]   data;
      logic [TRACE_REG_W-1:0]    rd;
   } trace_rec_t;

endpackage

// File: rtl/nanorv32_trace_fifo.sv
// Dual-push, single-pop first-word-fall-through FIFO. The caller never pushes
// more entries than free_slots reports; push1 is only used together with push0.
module nanorv32_trace_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 135
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push0,
   input  logic [WIDTH-1:0]         push0_data,
   input  logic                     push1,
   input  logic [WIDTH-1:0]         push1_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   free_slots
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] count;
   logic [PTR_W-1:0] wr_ptr_p1;
   logic             pop_ok;

   // The pop is credited before the free-slot count so a full FIFO that is
   // being drained this cycle can still accept one push.
   always_comb begin
      count      = wr_ptr_q - rd_ptr_q;
      empty      = (count == '0);
      pop_ok     = pop & ~empty;
      free_slots = PTR_W'(DEPTH) - count + PTR_W'(pop_ok);
      wr_ptr_p1  = wr_ptr_q + PTR_W'(1);
      wr_ptr_d   = wr_ptr_q + PTR_W'(push0) + PTR_W'(push1);
      rd_ptr_d   = rd_ptr_q + PTR_W'(pop_ok);
      head       = mem_q[rd_ptr_q[IDX_W-1:0]];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push0) mem_q[wr_ptr_q[IDX_W-1:0]]  <= push0_data;
      if (push1) mem_q[wr_ptr_p1[IDX_W-1:0]] <= push1_data;
   end

endmodule

// File: rtl/nanorv32_trace_capture.sv
// Retirement-trace collector: one record per retired instruction, with the
// load/store data phase merged in, streamed out through a FWFT FIFO.
module nanorv32_trace_capture
   import nanorv32_trace_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DROP_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              trace_en,
   input  logic              inst_ret,
   input  logic [31:0]       pc,
   input  logic [31:0]       instr,
   input  logic              write_rd,
   input  logic [4:0]        rd_idx,
   input  logic [31:0]       rd_val,
   input  logic              htransd,
   input  logic              hwrited,
   input  logic              hreadyd,
   input  logic [31:0]       haddrd,
   input  logic [31:0]       hwdatad,
   input  logic              write_rd2,
   input  logic [4:0]        rd2_idx,
   input  logic [31:0]       rd2_val,
   output logic              trace_valid,
   input  logic              trace_ready,
   output logic [1:0]        trace_kind,
   output logic [31:0]       trace_pc,
   output logic [31:0]       trace_instr,
   output logic [31:0]       trace_addr,
   output logic [31:0]       trace_data,
   output logic [4:0]        trace_reg,
   output logic [DROP_W-1:0] drop_cnt,
   input  logic              drop_clr
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   trace_state_e      state_q, state_d;
   logic [31:0]       pend_pc_q, pend_pc_d;
   logic [31:0]       pend_instr_q, pend_instr_d;
   logic [31:0]       pend_addr_q, pend_addr_d;
   logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
   logic [DROP_W:0]   drop_sum;

   logic              mem_ret, alu_ret, cpl;
   logic [1:0]        n_req, n_acc, n_drop;
   logic              push0, push1, pop, fifo_empty;
   logic [CNT_W-1:0]  free_slots;
   trace_rec_t        cpl_rec, alu_rec, push0_rec, head_rec;
   logic [TRACE_REC_W-1:0] fifo_head;

   // Retire and completion decode plus record assembly. The core stalls
   // retirement while a data phase is outstanding, so an ALU retire always
   // follows (or coincides with) the pending completion in program order.
   always_comb begin
      mem_ret = inst_ret & htransd & hreadyd & trace_en;
      alu_ret = inst_ret & ~htransd & trace_en;
      cpl     = (state_q != IDLE) & hreadyd;

      cpl_rec.kind  = (state_q == STORE_WAIT) ? TRACE_STORE : TRACE_LOAD;
      cpl_rec.pc    = pend_pc_q;
      cpl_rec.instr = pend_instr_q;
      cpl_rec.addr  = pend_addr_q;
      cpl_rec.data  = (state_q == STORE_WAIT) ? hwdatad : rd2_val;
      cpl_rec.rd    = (state_q == LOAD_WAIT && write_rd2) ? rd2_idx : 5'd0;

      alu_rec.kind  = TRACE_ALU;
      alu_rec.pc    = pc;
      alu_rec.instr = instr;
      alu_rec.addr  = 32'd0;
      alu_rec.data  = write_rd ? rd_val : 32'd0;
      alu_rec.rd    = write_rd ? rd_idx : 5'd0;

      push0_rec = cpl ? cpl_rec : alu_rec;
   end

   // Next-state: a new memory retire may be captured from IDLE or in the
   // same cycle the pending access completes.
   always_comb begin
      state_d      = state_q;
      pend_pc_d    = pend_pc_q;
      pend_instr_d = pend_instr_q;
      pend_addr_d  = pend_addr_q;
      if (state_q == IDLE || cpl) begin
         state_d = IDLE;
         if (mem_ret) begin
            state_d      = hwrited ? STORE_WAIT : LOAD_WAIT;
            pend_pc_d    = pc;
            pend_instr_d = instr;
            pend_addr_d  = haddrd;
         end
      end
   end

   // Admission: the completion is always the older record, so it takes the
   // first free slot and the ALU record is the one that gets dropped.
   always_comb begin
      n_req = {1'b0, cpl} + {1'b0, alu_ret};
      if (free_slots >= CNT_W'(n_req)) n_acc = n_req;
      else                             n_acc = free_slots[1:0];
      n_drop = n_req - n_acc;
      push0  = (n_acc != 2'd0);
      push1  = (n_acc == 2'd2);

      drop_sum = {1'b0, drop_cnt_q} + (DROP_W+1)'(n_drop);
      if (drop_clr)              drop_cnt_d = '0;
      else if (drop_sum[DROP_W]) drop_cnt_d = '1;
      else                       drop_cnt_d = drop_sum[DROP_W-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         pend_pc_q    <= '0;
         pend_instr_q <= '0;
         pend_addr_q  <= '0;
         drop_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         pend_pc_q    <= pend_pc_d;
         pend_instr_q <= pend_instr_d;
         pend_addr_q  <= pend_addr_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   nanorv32_trace_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (TRACE_REC_W)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push0      (push0),
      .push0_data (push0_rec),
      .push1      (push1),
      .push1_data (alu_rec),
      .pop        (pop),
      .head       (fifo_head),
      .empty      (fifo_empty),
      .free_slots (free_slots)
   );

   // Storage is not reset, so the head is masked to zero while empty.
   assign head_rec    = fifo_empty ? '0 : trace_rec_t'(fifo_head);
   assign pop         = ~fifo_empty & trace_ready;
   assign trace_valid = ~fifo_empty;
   assign trace_kind  = head_rec.kind;
   assign trace_pc    = head_rec.pc;
   assign trace_instr = head_rec.instr;
   assign trace_addr  = head_rec.addr;
   assign trace_data  = head_rec.data;
   assign trace_reg   = head_rec.rd;
   assign drop_cnt    = drop_cnt_q;

endmodule
